// File: rtl/ascii_uart_tx.sv
// Byte-stream to 8N1 UART transmitter: small FIFO, optional NUL filter,
// baud divider and frame serializer with a registered tx output.
module ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4,
    parameter int SKIP_NUL     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          clr_ovf,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             is_nul;
    logic             push;
    logic             pop;
    logic             drop;
    logic             baud_done;

    assign is_nul    = (SKIP_NUL != 0) && (in_data == 8'h00);
    assign in_ready  = (fifo_level < LVL_W'(FIFO_DEPTH));
    assign push      = in_valid && in_ready && !is_nul;
    assign drop      = in_valid && !in_ready && !is_nul;
    assign pop       = (state == S_IDLE) && (fifo_level != '0);
    assign baud_done = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign busy      = (state != S_IDLE) || (fifo_level != '0);

    // FIFO storage carries no reset; only pointers and level are control state.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            // A drop in the same cycle as a clear wins, so no overflow is lost.
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            shift <= mem[rd_ptr];
        end else if ((state == S_DATA) && baud_done) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state    <= S_START;
                        baud_cnt <= '0;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        state    <= S_DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        state    <= S_IDLE;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

    // tx follows the state one clock later, giving the pop-cycle gap before START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx <= 1'b1;
        end else begin
            case (state)
                S_START: tx <= 1'b0;
                S_DATA:  tx <= shift[0];
                default: tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Directed bench for ascii_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4, SKIP_NUL=1)
// with a table of per-cycle vectors and a small UART line decoder.
module tb_ascii_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       clr_ovf;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;
    logic       ovf;

    ascii_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .SKIP_NUL(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .clr_ovf(clr_ovf), .tx(tx), .busy(busy),
        .fifo_level(fifo_level), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int max_lvl = 0;
    int frame_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: start detected at cnt 0, bit i sampled mid-bit, stop at cnt 38.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       dec_active = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            dec_active <= 1'b0;
            dec_cnt    <= 0;
        end else if (!dec_active) begin
            if (tx == 1'b0) begin
                dec_active <= 1'b1;
                dec_cnt    <= 1;
                dec_byte   <= 8'h00;
                rx_t.push_back(cyc);
            end
        end else begin
            if (dec_cnt >= 6 && dec_cnt <= 34 && ((dec_cnt - 6) % 4 == 0))
                dec_byte[(dec_cnt - 6) / 4] <= tx;
            if (dec_cnt == 38) begin
                if (tx == 1'b1) rx_q.push_back(dec_byte);
                else frame_err <= frame_err + 1;
                dec_active <= 1'b0;
            end
            dec_cnt <= dec_cnt + 1;
        end
    end

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       clr;
        logic [2:0] lvl;
        logic       rdy;
        logic       ovf;
        logic       tx;
        logic       busy;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic vld, logic [7:0] data, logic clr, logic [2:0] lvl,
                                logic rdy, logic o, logic t, logic b);
        vec_t v;
        v.vld = vld; v.data = data; v.clr = clr; v.lvl = lvl;
        v.rdy = rdy; v.ovf = o; v.tx = t; v.busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    endtask

    task automatic wait_rx(input int n, input int max_cyc);
        int c;
        c = 0;
        while (rx_q.size() < n && c < max_cyc) begin
            tick();
            c++;
        end
        chk("rx_count", rx_q.size(), n);
    endtask

    function automatic int rxb(input int i);
        if (i < rx_q.size()) return int'(rx_q[i]);
        return -1;
    endfunction

    function automatic logic exp_tx(input int k, input logic [7:0] b);
        int j;
        if (k < 2) return 1'b1;
        j = (k - 2) / 4;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        return 1'b1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1, 8'h41, 0, 1, 1, 0, 1, 1);
        vecs[1]  = mk(1, 8'h42, 0, 1, 1, 0, 1, 1);
        vecs[2]  = mk(1, 8'h43, 0, 2, 1, 0, 0, 1);
        vecs[3]  = mk(1, 8'h44, 0, 3, 1, 0, 0, 1);
        vecs[4]  = mk(1, 8'h45, 0, 4, 0, 0, 0, 1);
        vecs[5]  = mk(1, 8'h46, 0, 4, 0, 1, 0, 1);
        vecs[6]  = mk(1, 8'h47, 0, 4, 0, 1, 1, 1);
        vecs[7]  = mk(1, 8'h48, 0, 4, 0, 1, 1, 1);
        vecs[8]  = mk(1, 8'h49, 0, 4, 0, 1, 1, 1);
        vecs[9]  = mk(1, 8'h4A, 0, 4, 0, 1, 1, 1);
        vecs[10] = mk(1, 8'h4B, 0, 4, 0, 1, 0, 1);
        vecs[11] = mk(1, 8'h4C, 0, 4, 0, 1, 0, 1);
        vecs[12] = mk(1, 8'h4D, 0, 4, 0, 1, 0, 1);
        vecs[13] = mk(1, 8'h4E, 0, 4, 0, 1, 0, 1);
        vecs[14] = mk(1, 8'h4F, 0, 4, 0, 1, 0, 1);
        vecs[15] = mk(1, 8'h50, 0, 4, 0, 1, 0, 1);
        vecs[16] = mk(1, 8'h51, 0, 4, 0, 1, 0, 1);
        vecs[17] = mk(1, 8'h52, 0, 4, 0, 1, 0, 1);
        vecs[18] = mk(1, 8'h53, 1, 4, 0, 1, 0, 1);
        vecs[19] = mk(1, 8'h54, 0, 4, 0, 1, 0, 1);
        vecs[20] = mk(0, 8'h00, 1, 4, 0, 0, 0, 1);
        vecs[21] = mk(0, 8'h00, 0, 4, 0, 0, 0, 1);

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1); chk("rst_busy", busy, 0);
        chk("rst_lvl", fifo_level, 0); chk("rst_ovf", ovf, 0); chk("rst_rdy", in_ready, 1);
        rst_n = 1'b1;

        // Idle line
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_tx", tx, 1); chk("idle_busy", busy, 0);
            chk("idle_rdy", in_ready, 1); chk("idle_lvl", fifo_level, 0);
        end

        // Single 'T' frame, cycle-exact
        rx_q.delete(); rx_t.delete();
        in_valid = 1'b1; in_data = 8'h54;
        tick();
        in_valid = 1'b0;
        chk("T_lvl", fifo_level, 1);
        for (int k = 1; k <= 45; k++) begin
            tick();
            chk($sformatf("T_tx_k%0d", k), tx, exp_tx(k, 8'h54));
            chk($sformatf("T_busy_k%0d", k), busy, (k <= 40) ? 1 : 0);
        end
        chk("T_rx_count", rx_q.size(), 1);
        chk("T_rx0", rxb(0), 32'h54);

        // "Taj" followed by NULs
        rx_q.delete(); rx_t.delete(); max_lvl = 0;
        in_valid = 1'b1;
        in_data = 8'h54; tick();
        in_data = 8'h61; tick();
        in_data = 8'h6A; tick();
        in_data = 8'h00;
        repeat (10) tick();
        in_valid = 1'b0;
        wait_rx(3, 200);
        chk("taj0", rxb(0), 32'h54); chk("taj1", rxb(1), 32'h61); chk("taj2", rxb(2), 32'h6A);
        chk("taj_gap01", (rx_t.size() >= 2) ? rx_t[1] - rx_t[0] : -1, 41);
        chk("taj_gap12", (rx_t.size() >= 3) ? rx_t[2] - rx_t[1] : -1, 41);
        chk("taj_maxlvl", max_lvl, 2);
        chk("taj_ovf", ovf, 0);
        repeat (5) tick();

        // Continuous offer into a 4-deep FIFO, overflow and clear
        rx_q.delete(); rx_t.delete();
        for (int i = 0; i < 22; i++) begin
            in_valid = vecs[i].vld; in_data = vecs[i].data; clr_ovf = vecs[i].clr;
            tick();
            chk($sformatf("tbl%0d_lvl", i + 1), fifo_level, vecs[i].lvl);
            chk($sformatf("tbl%0d_rdy", i + 1), in_ready, vecs[i].rdy);
            chk($sformatf("tbl%0d_ovf", i + 1), ovf, vecs[i].ovf);
            chk($sformatf("tbl%0d_tx", i + 1), tx, vecs[i].tx);
            chk($sformatf("tbl%0d_busy", i + 1), busy, vecs[i].busy);
        end
        in_valid = 1'b0; clr_ovf = 1'b0;
        for (int k = 23; k <= 42; k++) tick();
        chk("full_lvl", fifo_level, 4);
        chk("full_rdy", in_ready, 0);
        // Producer honours in_ready across the pop edge
        in_valid = in_ready; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        chk("pop_lvl", fifo_level, 3);
        chk("pop_rdy", in_ready, 1);
        chk("pop_ovf", ovf, 0);
        wait_rx(5, 300);
        for (int i = 0; i < 5; i++)
            chk($sformatf("fill_rx%0d", i), rxb(i), 32'h41 + i);
        repeat (5) tick();

        // Reset in the middle of a DATA bit
        rx_q.delete(); rx_t.delete();
        in_valid = 1'b1; in_data = 8'h61; tick();
        in_data = 8'h62; tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("pre_rst_tx", tx, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1); chk("mid_rst_lvl", fifo_level, 0);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_rdy", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_q.delete(); rx_t.delete();
        repeat (60) tick();
        chk("post_rst_rx_count", rx_q.size(), 0);
        chk("post_rst_busy", busy, 0);
        in_valid = 1'b1; in_data = 8'h41; tick();
        in_valid = 1'b0;
        wait_rx(1, 100);
        chk("post_rst_rx0", rxb(0), 32'h41);
        chk("frame_err", frame_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
